// File: rtl/sram_bank_ctrl_if.sv
// Request/response bundle between a load/store unit and sram_bank_ctrl.
// The master drives requests and the slave (the controller) returns one response per request.
interface sram_bank_ctrl_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic [DATA_W/8-1:0]   req_be;
    logic [ADDR_W-1:0]     req_addr;
    logic [DATA_W-1:0]     req_wdata;
    logic                  rsp_valid;
    logic [DATA_W-1:0]     rsp_rdata;
    logic                  rsp_misaligned;

    modport master (
        output req_valid, req_we, req_be, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_misaligned
    );

    modport slave (
        input  req_valid, req_we, req_be, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_misaligned
    );
endinterface

// File: rtl/sram_bank_ctrl.sv
// Byte-addressed single-port data memory with synchronous reads.
// A misaligned access is split into two word beats that wrap at the top of memory.
module sram_bank_ctrl #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    sram_bank_ctrl_if.slave bus
);
    localparam int NB     = DATA_W / 8;
    localparam int OW     = $clog2(NB);
    localparam int WW     = ADDR_W - OW;
    localparam int NWORDS = 1 << WW;

    typedef enum logic [1:0] {IDLE, ACC0, ACC1, RESP} state_t;

    state_t            state;
    state_t            state_next;

    logic [WW-1:0]     word_r;
    logic [OW-1:0]     off_r;
    logic              we_r;
    logic [NB-1:0]     be_r;
    logic [DATA_W-1:0] wdata_r;

    logic [DATA_W-1:0] mem [NWORDS];
    logic [DATA_W-1:0] rd0;
    logic [DATA_W-1:0] rsp_rdata_r;

    logic [WW-1:0]     word_idx;
    logic [DATA_W-1:0] word_rd;
    logic [DATA_W-1:0] lo_word;
    logic [DATA_W-1:0] rot_wdata;
    logic [DATA_W-1:0] asm_rdata;
    logic [NB-1:0]     lane_en;

    // The second beat addresses the following word; the index width makes it wrap.
    assign word_idx = (state == ACC1) ? word_r + WW'(1) : word_r;
    assign word_rd  = mem[word_idx];
    assign lo_word  = (state == ACC0) ? word_rd : rd0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (bus.req_valid) state_next = ACC0;
            ACC0:    state_next = (off_r != '0) ? ACC1 : RESP;
            ACC1:    state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        bus.req_ready      = 1'b0;
        bus.rsp_valid      = 1'b0;
        bus.rsp_misaligned = 1'b0;
        case (state)
            IDLE: bus.req_ready = 1'b1;
            RESP: begin
                bus.rsp_valid      = 1'b1;
                bus.rsp_misaligned = (off_r != '0);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_r  <= '0;
            off_r   <= '0;
            we_r    <= 1'b0;
            be_r    <= '0;
            wdata_r <= '0;
        end else if (state == IDLE && bus.req_valid) begin
            word_r  <= bus.req_addr[ADDR_W-1:OW];
            off_r   <= bus.req_addr[OW-1:0];
            we_r    <= bus.req_we;
            be_r    <= bus.req_be;
            wdata_r <= bus.req_wdata;
        end
    end

    // Word position p holds request lane (p - off); beat 0 owns positions >= off, beat 1 the rest.
    for (genvar p = 0; p < NB; p++) begin : g_lane
        logic [OW-1:0] src;
        logic [OW-1:0] pos;

        assign src = OW'(p) - off_r;
        assign pos = OW'(p) + off_r;

        assign rot_wdata[p*8 +: 8] = wdata_r[{src, 3'b000} +: 8];
        assign lane_en[p] = we_r && be_r[src] &&
                            (((state == ACC0) && (OW'(p) >= off_r)) ||
                             ((state == ACC1) && (OW'(p) <  off_r)));
        assign asm_rdata[p*8 +: 8] = ((p + int'(off_r)) < NB) ? lo_word[{pos, 3'b000} +: 8]
                                                               : word_rd[{pos, 3'b000} +: 8];
    end

    always_ff @(posedge clk) begin
        for (int p = 0; p < NB; p++) begin
            if (lane_en[p]) begin
                mem[word_idx][p*8 +: 8] <= rot_wdata[p*8 +: 8];
            end
        end
    end

    // The response word is loaded on the edge that enters RESP and held until the next one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd0         <= '0;
            rsp_rdata_r <= '0;
        end else begin
            if (state == ACC0) begin
                rd0 <= word_rd;
            end
            if (state_next == RESP) begin
                rsp_rdata_r <= we_r ? '0 : asm_rdata;
            end
        end
    end

    assign bus.rsp_rdata = rsp_rdata_r;
endmodule

// File: tb/tb_sram_bank_ctrl.sv
// Self-checking bench for sram_bank_ctrl: directed scenarios plus randomized traffic
// on a 16/32 instance and a 12/64 instance, checked against a byte-array reference.
module tb_sram_bank_ctrl;
    logic clk;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    logic [7:0] ref_a   [65536];
    bit         known_a [65536];
    logic [7:0] ref_b   [4096];
    bit         known_b [4096];

    sram_bank_ctrl_if #(.ADDR_W(16), .DATA_W(32)) bus_a ();
    sram_bank_ctrl_if #(.ADDR_W(12), .DATA_W(64)) bus_b ();

    sram_bank_ctrl #(.ADDR_W(16), .DATA_W(32)) dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));
    sram_bank_ctrl #(.ADDR_W(12), .DATA_W(64)) dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void model_write(input bit alt, input logic [15:0] addr,
                                        input logic [7:0] be, input logic [63:0] wdata);
        int nb   = alt ? 8 : 4;
        int span = alt ? 4096 : 65536;
        for (int i = 0; i < nb; i++) begin
            int a = (int'(addr) + i) % span;
            if (be[i]) begin
                if (alt) begin ref_b[a] = wdata[i*8 +: 8]; known_b[a] = 1'b1; end
                else     begin ref_a[a] = wdata[i*8 +: 8]; known_a[a] = 1'b1; end
            end
        end
    endfunction

    function automatic void model_read(input bit alt, input logic [15:0] addr,
                                       output logic [63:0] exp, output logic [63:0] mask);
        int nb   = alt ? 8 : 4;
        int span = alt ? 4096 : 65536;
        exp  = '0;
        mask = '0;
        for (int i = 0; i < nb; i++) begin
            int a = (int'(addr) + i) % span;
            if (alt && known_b[a]) begin exp[i*8 +: 8] = ref_b[a]; mask[i*8 +: 8] = 8'hFF; end
            if (!alt && known_a[a]) begin exp[i*8 +: 8] = ref_a[a]; mask[i*8 +: 8] = 8'hFF; end
        end
    endfunction

    function automatic logic ready_of(input bit alt);
        return alt ? bus_b.req_ready : bus_a.req_ready;
    endfunction

    function automatic logic rvalid_of(input bit alt);
        return alt ? bus_b.rsp_valid : bus_a.rsp_valid;
    endfunction

    task automatic drive_req(input bit alt, input bit valid, input bit we, input logic [7:0] be,
                             input logic [15:0] addr, input logic [63:0] wdata);
        if (alt) begin
            bus_b.req_valid = valid; bus_b.req_we = we; bus_b.req_be = be;
            bus_b.req_addr  = addr[11:0]; bus_b.req_wdata = wdata;
        end else begin
            bus_a.req_valid = valid; bus_a.req_we = we; bus_a.req_be = be[3:0];
            bus_a.req_addr  = addr; bus_a.req_wdata = wdata[31:0];
        end
    endtask

    // One request; lat counts cycles from the accept edge (ACC0 is cycle 1), -1 on timeout.
    task automatic applyStimulus(input bit alt, input bit we, input logic [7:0] be,
                                 input logic [15:0] addr, input logic [63:0] wdata,
                                 output logic [63:0] rdata, output logic mis, output int lat);
        bit accepted = 1'b0;
        lat   = -1;
        rdata = '0;
        mis   = 1'b0;
        @(negedge clk);
        drive_req(alt, 1'b1, we, be, addr, wdata);
        for (int c = 0; c < 20; c++) begin
            if (ready_of(alt)) begin
                @(posedge clk);
                accepted = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!accepted) begin
            checks++; errors++;
            $display("[TB] FAIL accept_timeout addr %h got no req_ready want req_ready", addr);
            drive_req(alt, 1'b0, 1'b0, 8'h0, 16'h0, 64'h0);
            return;
        end
        #1;
        drive_req(alt, 1'b0, 1'b0, 8'h0, 16'h0, 64'h0);
        for (int c = 1; c <= 10; c++) begin
            if (rvalid_of(alt)) begin
                lat   = c;
                rdata = alt ? bus_b.rsp_rdata : {32'h0, bus_a.rsp_rdata};
                mis   = alt ? bus_b.rsp_misaligned : bus_a.rsp_misaligned;
                break;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive_req(1'b0, 1'b0, 1'b0, 8'h0, 16'h0, 64'h0);
        drive_req(1'b1, 1'b0, 1'b0, 8'h0, 16'h0, 64'h0);
        repeat (2) @(posedge clk);
        #1;
        checks++; if (bus_a.req_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_ready got %b want 1", bus_a.req_ready); end
        checks++; if (bus_a.rsp_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_rsp_valid got %b want 0", bus_a.rsp_valid); end
        checks++; if (bus_a.rsp_rdata !== 32'h0) begin errors++; $display("[TB] FAIL reset_rdata got %h want 0", bus_a.rsp_rdata); end
        checks++; if (bus_a.rsp_misaligned !== 1'b0) begin errors++; $display("[TB] FAIL reset_mis got %b want 0", bus_a.rsp_misaligned); end
        checks++; if (bus_b.req_ready !== 1'b1 || bus_b.rsp_rdata !== 64'h0) begin errors++; $display("[TB] FAIL reset_alt got ready %b rdata %h want 1 0", bus_b.req_ready, bus_b.rsp_rdata); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_aligned();
        logic [63:0] rd; logic mis; int lat;
        applyStimulus(1'b0, 1'b1, 8'hF, 16'h0010, 64'hDEADBEEF, rd, mis, lat);
        model_write(1'b0, 16'h0010, 8'hF, 64'hDEADBEEF);
        checks++; if (lat !== 2 || mis !== 1'b0 || rd !== 64'h0) begin errors++; $display("[TB] FAIL aligned_write got lat %0d mis %b rd %h want 2 0 0", lat, mis, rd); end
        applyStimulus(1'b0, 1'b0, 8'h0, 16'h0010, 64'h0, rd, mis, lat);
        checks++; if (rd !== 64'hDEADBEEF) begin errors++; $display("[TB] FAIL aligned_read got %h want deadbeef", rd); end
        checks++; if (lat !== 2) begin errors++; $display("[TB] FAIL aligned_latency got %0d want 2", lat); end
        checks++; if (mis !== 1'b0) begin errors++; $display("[TB] FAIL aligned_mis got %b want 0", mis); end
    endtask

    task automatic test_misaligned();
        logic [63:0] rd; logic mis; int lat;
        applyStimulus(1'b0, 1'b1, 8'hF, 16'h0013, 64'h11223344, rd, mis, lat);
        model_write(1'b0, 16'h0013, 8'hF, 64'h11223344);
        checks++; if (lat !== 3) begin errors++; $display("[TB] FAIL mis_write_latency got %0d want 3", lat); end
        checks++; if (mis !== 1'b1) begin errors++; $display("[TB] FAIL mis_write_flag got %b want 1", mis); end
        applyStimulus(1'b0, 1'b0, 8'h0, 16'h0010, 64'h0, rd, mis, lat);
        checks++; if (rd !== 64'h44ADBEEF) begin errors++; $display("[TB] FAIL mis_low_word got %h want 44adbeef", rd); end
        applyStimulus(1'b0, 1'b0, 8'h0, 16'h0014, 64'h0, rd, mis, lat);
        checks++; if (rd[23:0] !== 24'h112233) begin errors++; $display("[TB] FAIL mis_high_word got %h want 112233", rd[23:0]); end
        applyStimulus(1'b0, 1'b0, 8'h0, 16'h0013, 64'h0, rd, mis, lat);
        checks++; if (rd !== 64'h11223344 || lat !== 3 || mis !== 1'b1) begin errors++; $display("[TB] FAIL mis_read got %h lat %0d mis %b want 11223344 3 1", rd, lat, mis); end
    endtask

    task automatic test_wrap();
        logic [63:0] rd; logic mis; int lat;
        applyStimulus(1'b0, 1'b1, 8'hF, 16'hFFFE, 64'hCAFEF00D, rd, mis, lat);
        model_write(1'b0, 16'hFFFE, 8'hF, 64'hCAFEF00D);
        applyStimulus(1'b0, 1'b0, 8'h0, 16'hFFFE, 64'h0, rd, mis, lat);
        checks++; if (rd !== 64'hCAFEF00D) begin errors++; $display("[TB] FAIL wrap_read got %h want cafef00d", rd); end
        applyStimulus(1'b0, 1'b0, 8'h0, 16'h0000, 64'h0, rd, mis, lat);
        checks++; if (rd[15:0] !== 16'hCAFE) begin errors++; $display("[TB] FAIL wrap_low got %h want cafe", rd[15:0]); end
    endtask

    task automatic test_partial();
        logic [63:0] rd; logic mis; int lat;
        applyStimulus(1'b0, 1'b1, 8'hF, 16'h0020, 64'h12345678, rd, mis, lat);
        model_write(1'b0, 16'h0020, 8'hF, 64'h12345678);
        applyStimulus(1'b0, 1'b1, 8'h4, 16'h0020, 64'h00AB0000, rd, mis, lat);
        model_write(1'b0, 16'h0020, 8'h4, 64'h00AB0000);
        checks++; if (lat !== 2) begin errors++; $display("[TB] FAIL partial_rsp got lat %0d want 2", lat); end
        @(posedge clk); #1;
        checks++; if (bus_a.rsp_valid !== 1'b0) begin errors++; $display("[TB] FAIL partial_pulse got %b want 0", bus_a.rsp_valid); end
        applyStimulus(1'b0, 1'b1, 8'h0, 16'h0020, 64'hFFFFFFFF, rd, mis, lat);
        checks++; if (lat !== 2) begin errors++; $display("[TB] FAIL be0_rsp got lat %0d want 2", lat); end
        @(posedge clk); #1;
        checks++; if (bus_a.rsp_valid !== 1'b0) begin errors++; $display("[TB] FAIL be0_pulse got %b want 0", bus_a.rsp_valid); end
        applyStimulus(1'b0, 1'b0, 8'h0, 16'h0020, 64'h0, rd, mis, lat);
        checks++; if (rd !== 64'h12AB5678) begin errors++; $display("[TB] FAIL partial_read got %h want 12ab5678", rd); end
        repeat (3) @(posedge clk);
        #1;
        checks++; if (bus_a.rsp_rdata !== 32'h12AB5678) begin errors++; $display("[TB] FAIL rdata_hold got %h want 12ab5678", bus_a.rsp_rdata); end
    endtask

    task automatic test_handshake();
        logic [15:0] addrs [4];
        logic [15:0] pend [$];
        logic [63:0] rd, exp, mask;
        logic        mis, prev_ready, valid_now;
        int          lat, accepts, rsps, since;
        addrs = '{16'h0010, 16'h0020, 16'h0040, 16'h0044};
        applyStimulus(1'b0, 1'b1, 8'hF, 16'h0040, 64'hA5A55A5A, rd, mis, lat);
        model_write(1'b0, 16'h0040, 8'hF, 64'hA5A55A5A);
        applyStimulus(1'b0, 1'b1, 8'hF, 16'h0044, 64'h0F1E2D3C, rd, mis, lat);
        model_write(1'b0, 16'h0044, 8'hF, 64'h0F1E2D3C);
        accepts = 0; rsps = 0; since = -1;
        @(negedge clk);
        drive_req(1'b0, 1'b1, 1'b0, 8'h0, addrs[0], 64'h0);
        valid_now  = 1'b1;
        prev_ready = bus_a.req_ready;
        for (int c = 0; c < 40 && rsps < 4; c++) begin
            @(posedge clk); #1;
            if (prev_ready && valid_now) begin
                pend.push_back(addrs[accepts]);
                accepts++;
                since = 0;
                if (accepts < 4) drive_req(1'b0, 1'b1, 1'b0, 8'h0, addrs[accepts], 64'h0);
                else begin drive_req(1'b0, 1'b0, 1'b0, 8'h0, 16'h0, 64'h0); valid_now = 1'b0; end
            end else if (since >= 0) begin
                since++;
            end
            if (since >= 0) begin
                checks++; if (bus_a.req_ready !== (since >= 2)) begin errors++; $display("[TB] FAIL hs_ready cyc %0d got %b want %b", c, bus_a.req_ready, since >= 2); end
                checks++; if (bus_a.rsp_valid !== (since == 1)) begin errors++; $display("[TB] FAIL hs_rsp_valid cyc %0d got %b want %b", c, bus_a.rsp_valid, since == 1); end
            end
            if (bus_a.rsp_valid === 1'b1 && pend.size() > 0) begin
                rsps++;
                model_read(1'b0, pend.pop_front(), exp, mask);
                checks++; if (({32'h0, bus_a.rsp_rdata} & mask) !== (exp & mask)) begin errors++; $display("[TB] FAIL hs_data got %h want %h", bus_a.rsp_rdata, exp); end
            end
            prev_ready = bus_a.req_ready;
        end
        checks++; if (accepts != 4 || rsps != 4) begin errors++; $display("[TB] FAIL hs_count got %0d/%0d want 4/4", accepts, rsps); end
    endtask

    task automatic test_reset_mid();
        logic [63:0] rd; logic mis; int lat; bit seen;
        applyStimulus(1'b0, 1'b0, 8'h0, 16'h0010, 64'h0, rd, mis, lat);
        @(posedge clk); #1;
        @(negedge clk);
        checks++; if (bus_a.req_ready !== 1'b1) begin errors++; $display("[TB] FAIL rm_idle got %b want 1", bus_a.req_ready); end
        drive_req(1'b0, 1'b1, 1'b0, 8'h0, 16'h0013, 64'h0);
        @(posedge clk); #1;
        drive_req(1'b0, 1'b0, 1'b0, 8'h0, 16'h0, 64'h0);
        @(posedge clk); #1;
        checks++; if (bus_a.req_ready !== 1'b0 || bus_a.rsp_valid !== 1'b0) begin errors++; $display("[TB] FAIL rm_busy got ready %b valid %b want 0 0", bus_a.req_ready, bus_a.rsp_valid); end
        rst_n = 1'b0;
        #1;
        checks++; if (bus_a.rsp_valid !== 1'b0) begin errors++; $display("[TB] FAIL rm_valid got %b want 0", bus_a.rsp_valid); end
        checks++; if (bus_a.rsp_rdata !== 32'h0) begin errors++; $display("[TB] FAIL rm_rdata got %h want 0", bus_a.rsp_rdata); end
        checks++; if (bus_a.req_ready !== 1'b1) begin errors++; $display("[TB] FAIL rm_ready got %b want 1", bus_a.req_ready); end
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (6) begin @(posedge clk); #1; if (bus_a.rsp_valid === 1'b1) seen = 1'b1; end
        checks++; if (seen) begin errors++; $display("[TB] FAIL rm_no_rsp got response want none"); end
        applyStimulus(1'b0, 1'b0, 8'h0, 16'h0013, 64'h0, rd, mis, lat);
        checks++; if (rd !== 64'h11223344 || lat !== 3) begin errors++; $display("[TB] FAIL rm_after got %h lat %0d want 11223344 3", rd, lat); end
    endtask

    task automatic test_alt();
        logic [63:0] rd; logic mis; int lat;
        applyStimulus(1'b1, 1'b1, 8'hFF, 16'h010, 64'h1122334455667788, rd, mis, lat);
        model_write(1'b1, 16'h010, 8'hFF, 64'h1122334455667788);
        applyStimulus(1'b1, 1'b0, 8'h0, 16'h010, 64'h0, rd, mis, lat);
        checks++; if (rd !== 64'h1122334455667788 || lat !== 2 || mis !== 1'b0) begin errors++; $display("[TB] FAIL alt_aligned got %h lat %0d mis %b", rd, lat, mis); end
        applyStimulus(1'b1, 1'b1, 8'hFF, 16'h013, 64'hA1A2A3A4A5A6A7A8, rd, mis, lat);
        model_write(1'b1, 16'h013, 8'hFF, 64'hA1A2A3A4A5A6A7A8);
        checks++; if (lat !== 3 || mis !== 1'b1) begin errors++; $display("[TB] FAIL alt_mis_write got lat %0d mis %b want 3 1", lat, mis); end
        applyStimulus(1'b1, 1'b0, 8'h0, 16'h010, 64'h0, rd, mis, lat);
        checks++; if (rd !== 64'hA4A5A6A7A8667788) begin errors++; $display("[TB] FAIL alt_mis_read got %h want a4a5a6a7a8667788", rd); end
        applyStimulus(1'b1, 1'b1, 8'hFF, 16'hFFE, 64'h0102030405060708, rd, mis, lat);
        model_write(1'b1, 16'hFFE, 8'hFF, 64'h0102030405060708);
        applyStimulus(1'b1, 1'b0, 8'h0, 16'hFFE, 64'h0, rd, mis, lat);
        checks++; if (rd !== 64'h0102030405060708 || lat !== 3) begin errors++; $display("[TB] FAIL alt_wrap got %h lat %0d", rd, lat); end
        applyStimulus(1'b1, 1'b0, 8'h0, 16'h000, 64'h0, rd, mis, lat);
        checks++; if (rd[47:0] !== 48'h010203040506) begin errors++; $display("[TB] FAIL alt_wrap_low got %h want 010203040506", rd[47:0]); end
    endtask

    task automatic test_random();
        logic [63:0] rd, exp, mask, wdata;
        logic [15:0] addr;
        logic [7:0]  be;
        logic        mis, we, want_mis;
        int          lat, span, nb;
        bit          alt;
        for (int n = 0; n < 60; n++) begin
            alt   = 1'($urandom_range(0, 1));
            span  = alt ? 4096 : 65536;
            nb    = alt ? 8 : 4;
            addr  = 16'((($urandom_range(0, 1) != 0 ? 256 : span - 16) + int'($urandom_range(0, 31))) % span);
            we    = 1'($urandom_range(0, 1));
            be    = 8'($urandom & ((1 << nb) - 1));
            wdata = {$urandom, $urandom};
            want_mis = (int'(addr) % nb) != 0;
            applyStimulus(alt, we, be, addr, wdata, rd, mis, lat);
            checks++; if (lat !== (want_mis ? 3 : 2)) begin errors++; $display("[TB] FAIL rand_latency op %0d addr %h got %0d want %0d", n, addr, lat, want_mis ? 3 : 2); end
            checks++; if (mis !== want_mis) begin errors++; $display("[TB] FAIL rand_mis op %0d addr %h got %b want %b", n, addr, mis, want_mis); end
            if (we) begin
                model_write(alt, addr, be, wdata);
                checks++; if (rd !== 64'h0) begin errors++; $display("[TB] FAIL rand_wr_rdata op %0d got %h want 0", n, rd); end
            end else begin
                model_read(alt, addr, exp, mask);
                checks++; if ((rd & mask) !== (exp & mask)) begin errors++; $display("[TB] FAIL rand_data op %0d alt %0d addr %h got %h want %h", n, alt, addr, rd & mask, exp & mask); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_aligned();
        test_misaligned();
        test_wrap();
        test_partial();
        test_handshake();
        test_reset_mid();
        test_alt();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
